// File: rtl/bus_memory_pkg.sv
// Shared types for bus_memory: loader FSM state encoding.
// The optional MMIO output register is enabled with BUS_MEMORY_MMIO_OUT_EN.
package bus_memory_pkg;

   typedef enum logic [1:0] {
      MEM_STATE_LOAD  = 2'd0,
      MEM_STATE_DRAIN = 2'd1,
      MEM_STATE_RUN   = 2'd2
   } mem_state_t;

endpackage

// File: rtl/bus_memory_loader.sv
// Boot loader for bus_memory: accepts a valid/ready byte stream into RAM,
// then walks LOAD -> DRAIN -> RUN and stays in RUN until reset.
import bus_memory_pkg::*;

module bus_memory_loader #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int LOAD_LEN   = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_valid,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  load_last,
   output logic                  load_ready,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [DATA_WIDTH-1:0] wdata,
   output mem_state_t            state
);

   // Handshake: a byte transfers on a rising edge where load_valid && load_ready.
   mem_state_t            state_next;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [ADDR_WIDTH-1:0] ptr_next;
   logic                  at_limit;

   assign at_limit = (ptr == ADDR_WIDTH'(LOAD_LEN - 1));
   assign waddr    = ptr;
   assign wdata    = load_data;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= MEM_STATE_LOAD;
         ptr   <= '0;
      end else begin
         state <= state_next;
         ptr   <= ptr_next;
      end
   end

   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      load_ready = 1'b0;
      we         = 1'b0;
      case (state)
         MEM_STATE_LOAD: begin
            load_ready = 1'b1;
            if (load_valid) begin
               we = 1'b1;
               // ptr only advances while staying in LOAD, so it can never wrap
               if (load_last || at_limit) state_next = MEM_STATE_DRAIN;
               else                       ptr_next   = ptr + 1'b1;
            end
         end
         MEM_STATE_DRAIN: state_next = MEM_STATE_RUN;
         MEM_STATE_RUN:   state_next = MEM_STATE_RUN;
         default:         state_next = MEM_STATE_LOAD;
      endcase
   end

endmodule

// File: rtl/bus_memory.sv
// CPU-side memory responder: RAM on a shared tri-state bus, boot-filled by a loader.
// Define BUS_MEMORY_MMIO_OUT_EN to map the all-ones address to an output register.
import bus_memory_pkg::*;

module bus_memory #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int LOAD_LEN   = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] addr_bus,
   input  logic                  c_ri,
   input  logic                  c_ro,
   inout  wire  [DATA_WIDTH-1:0] bus,
   input  logic                  load_valid,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  load_last,
   output logic                  load_ready,
   output logic                  cpu_reset,
   output logic                  load_done,
`ifdef BUS_MEMORY_MMIO_OUT_EN
   output logic [DATA_WIDTH-1:0] out_port,
   output logic                  out_strobe,
`endif
   output logic                  bus_conflict
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  ld_we;
   logic [ADDR_WIDTH-1:0] ld_addr;
   logic [DATA_WIDTH-1:0] ld_data;
   mem_state_t            state;
   logic                  run;
   logic                  cpu_write;
   logic                  ram_write;
   logic                  drive_en;
   logic [DATA_WIDTH-1:0] rd_data;

   bus_memory_loader #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .LOAD_LEN   (LOAD_LEN)
   ) u_loader (
      .clk        (clk),
      .reset      (reset),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_last  (load_last),
      .load_ready (load_ready),
      .we         (ld_we),
      .waddr      (ld_addr),
      .wdata      (ld_data),
      .state      (state)
   );

   assign run       = (state == MEM_STATE_RUN);
   assign cpu_reset = !run;
   assign load_done = run;
   assign cpu_write = run && c_ri;
   // On a strobe conflict the write still happens but the bus is left undriven
   assign drive_en  = run && c_ro && !c_ri;

`ifdef BUS_MEMORY_MMIO_OUT_EN
   logic out_sel;
   assign out_sel   = (addr_bus == '1);
   assign ram_write = cpu_write && !out_sel;
   assign rd_data   = out_sel ? out_port : mem[addr_bus];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_port   <= '0;
         out_strobe <= 1'b0;
      end else begin
         out_strobe <= cpu_write && out_sel;
         if (cpu_write && out_sel) out_port <= bus;
      end
   end
`else
   assign ram_write = cpu_write;
   assign rd_data   = mem[addr_bus];
`endif

   // RAM has no reset so a reload keeps every byte it does not overwrite
   always_ff @(posedge clk) begin
      if (ld_we)          mem[ld_addr]  <= ld_data;
      else if (ram_write) mem[addr_bus] <= bus;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                  bus_conflict <= 1'b0;
      else if (run && c_ri && c_ro) bus_conflict <= 1'b1;
   end

   assign bus = drive_en ? rd_data : 'z;

endmodule
